// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI master/memory side and spi_slave_if.
// Signals:
//   SS_n     - slave select, active low
//   MOSI     - serial command data, MSB first
//   MISO     - serial read data, MSB first, 0 when idle
//   rx_data  - assembled 10-bit command word ([9:8] command, [7:0] address/data)
//   rx_valid - one-cycle strobe qualifying rx_data
//   tx_data  - read byte from memory
//   tx_valid - tx_data valid, may stay high indefinitely
// The slave modport is the view taken by spi_slave_if; master is the environment.
interface spi_slave_if_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// Serial front end of the SPI-to-memory path.
// Deserialises 10-bit command words from MOSI (one bit per rising clk edge while SS_n is low),
// presents them as rx_data/rx_valid, and for read-data frames captures the memory's tx_data
// byte and shifts it back out on MISO, MSB first.
// Ports:
//   clk - system clock, also the SPI bit clock
//   rst - synchronous active-high reset
//   bus - spi_slave_if_if.slave: SS_n, MOSI, MISO, rx_data, rx_valid, tx_data, tx_valid
module spi_slave_if (
    input  logic                 clk,
    input  logic                 rst,
    spi_slave_if_if.slave        bus
);

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       frame_done_q, frame_done_d;
    logic [9:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rd_addr_done_q, rd_addr_done_d;
    logic       wait_q, wait_d;
    logic       shifting_q, shifting_d;
    logic [6:0] tx_sr_q, tx_sr_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic       miso_q, miso_d;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        frame_done_d   = frame_done_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        wait_d         = wait_q;
        shifting_d     = shifting_q;
        tx_sr_d        = tx_sr_q;
        tx_cnt_d       = tx_cnt_q;
        miso_d         = miso_q;

        if (state_q != StIdle && bus.SS_n) begin
            // Abort: drop the frame silently, rx_data keeps its last value.
            state_d      = StIdle;
            bit_cnt_d    = 4'd0;
            frame_done_d = 1'b0;
            wait_d       = 1'b0;
            shifting_d   = 1'b0;
            tx_cnt_d     = 3'd0;
            miso_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    bit_cnt_d    = 4'd0;
                    frame_done_d = 1'b0;
                    wait_d       = 1'b0;
                    shifting_d   = 1'b0;
                    miso_d       = 1'b0;
                    if (!bus.SS_n) begin
                        state_d = StChkCmd;
                    end
                end

                StChkCmd: begin
                    shift_d      = {shift_q[7:0], bus.MOSI};
                    bit_cnt_d    = 4'd0;
                    frame_done_d = 1'b0;
                    if (!bus.MOSI) begin
                        state_d = StWrite;
                    end else if (rd_addr_done_q) begin
                        state_d = StReadData;
                    end else begin
                        state_d = StReadAdd;
                    end
                end

                StWrite, StReadAdd, StReadData: begin
                    if (!frame_done_q) begin
                        shift_d   = {shift_q[7:0], bus.MOSI};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // bit_cnt_q == 8 means this edge samples bit 0.
                        if (bit_cnt_q == 4'd8) begin
                            frame_done_d = 1'b1;
                            rx_data_d    = {shift_q, bus.MOSI};
                            rx_valid_d   = 1'b1;
                            if (state_q == StReadAdd) begin
                                rd_addr_done_d = 1'b1;
                            end
                            if (state_q == StReadData) begin
                                rd_addr_done_d = 1'b0;
                                wait_d         = 1'b1;
                            end
                        end
                    end

                    if (state_q == StReadData) begin
                        if (wait_q && bus.tx_valid) begin
                            // Capture once; later tx_valid is ignored since wait is cleared.
                            wait_d     = 1'b0;
                            shifting_d = 1'b1;
                            miso_d     = bus.tx_data[7];
                            tx_sr_d    = bus.tx_data[6:0];
                            tx_cnt_d   = 3'd7;
                        end else if (shifting_q) begin
                            if (tx_cnt_q != 3'd0) begin
                                miso_d   = tx_sr_q[6];
                                tx_sr_d  = {tx_sr_q[5:0], 1'b0};
                                tx_cnt_d = tx_cnt_q - 3'd1;
                            end else begin
                                miso_d     = 1'b0;
                                shifting_d = 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            shift_q        <= 9'd0;
            bit_cnt_q      <= 4'd0;
            frame_done_q   <= 1'b0;
            rx_data_q      <= 10'd0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            wait_q         <= 1'b0;
            shifting_q     <= 1'b0;
            tx_sr_q        <= 7'd0;
            tx_cnt_q       <= 3'd0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_done_q   <= frame_done_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            wait_q         <= wait_d;
            shifting_q     <= shifting_d;
            tx_sr_q        <= tx_sr_d;
            tx_cnt_q       <= tx_cnt_d;
            miso_q         <= miso_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.MISO     = miso_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if. Inputs change on the falling edge, outputs are checked on
// the falling edge; rx_valid pulses and MISO ones are counted at every rising edge.
module tb_spi_slave_if;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_rxv;
    int   n_miso;
    logic [9:0] last_rx;

    spi_slave_if_if bus ();

    spi_slave_if dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rx_valid) n_rxv <= n_rxv + 1;
        if (bus.MISO)     n_miso <= n_miso + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after E10 with SS_n still low.
    task automatic send_word(input logic [9:0] w);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            check_eq("no_early_valid", {31'd0, bus.rx_valid}, 32'd0);
            bus.MOSI = w[i];
        end
        @(negedge clk);
        check_eq("rx_valid_e10", {31'd0, bus.rx_valid}, 32'd1);
        check_eq("rx_data", {22'd0, bus.rx_data}, {22'd0, w});
        last_rx = w;
    endtask

    task automatic wr_frame(input logic [9:0] w);
        int rxv0;
        int mi0;
        rxv0 = n_rxv;
        mi0  = n_miso;
        send_word(w);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check_eq("wr_one_pulse", n_rxv - rxv0, 32'd1);
        check_eq("wr_miso_quiet", n_miso - mi0, 32'd0);
    endtask

    // Read-address frame with tx_valid held high throughout: nothing may be shifted out.
    task automatic rd_addr_frame(input logic [9:0] w);
        int rxv0;
        int mi0;
        rxv0 = n_rxv;
        mi0  = n_miso;
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        send_word(w);
        repeat (10) @(negedge clk);
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check_eq("ra_one_pulse", n_rxv - rxv0, 32'd1);
        check_eq("ra_miso_quiet", n_miso - mi0, 32'd0);
    endtask

    // Read-data frame. tx_valid rises 'delay' cycles later than the nominal E11 registration.
    // rst_bit >= 0 applies a one-cycle reset right after that MISO bit is seen.
    // 'hold' extra cycles keep SS_n low with tx_valid still high after the byte.
    task automatic rd_frame(input logic [9:0] w, input logic [7:0] b, input int delay,
                            input int rst_bit, input int hold);
        int rxv0;
        int mi0;
        rxv0 = n_rxv;
        mi0  = n_miso;
        bus.tx_valid = 1'b0;
        bus.tx_data  = b;
        send_word(w);
        repeat (delay) begin
            @(negedge clk);
            check_eq("miso_waiting", {31'd0, bus.MISO}, 32'd0);
        end
        @(negedge clk);
        check_eq("miso_pre_capture", {31'd0, bus.MISO}, 32'd0);
        bus.tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus.tx_data = ~b;  // capture must already have happened
            check_eq($sformatf("miso_bit%0d", i), {31'd0, bus.MISO}, {31'd0, b[i]});
            if (i == rst_bit) begin
                rst      = 1'b1;
                bus.SS_n = 1'b1;
                @(negedge clk);
                rst          = 1'b0;
                bus.tx_valid = 1'b0;
                check_eq("rst_miso", {31'd0, bus.MISO}, 32'd0);
                check_eq("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
                check_eq("rst_rx_data", {22'd0, bus.rx_data}, 32'd0);
                last_rx = 10'd0;
                return;
            end
        end
        @(negedge clk);
        check_eq("miso_after_byte", {31'd0, bus.MISO}, 32'd0);
        repeat (hold) begin
            @(negedge clk);
            check_eq("miso_no_second_byte", {31'd0, bus.MISO}, 32'd0);
        end
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check_eq("rd_one_pulse", n_rxv - rxv0, 32'd1);
        check_eq("rd_miso_ones", n_miso - mi0, $countones(b));
    endtask

    initial begin
        int rxv0;
        n_checks     = 0;
        n_errors     = 0;
        n_rxv        = 0;
        n_miso       = 0;
        last_rx      = 10'd0;
        rst          = 1'b1;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_rx_data", {22'd0, bus.rx_data}, 32'd0);
        check_eq("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check_eq("reset_miso", {31'd0, bus.MISO}, 32'd0);
        @(negedge clk);

        // Write address, write data (back to back, one idle cycle).
        wr_frame(10'h03C);
        wr_frame(10'h1A5);

        // Read address (rd_addr_done must still be 0), then read data of 0xA5.
        rd_addr_frame(10'h23C);
        rd_frame(10'h300, 8'hA5, 0, -1, 0);

        // rd_addr_done cleared by the read-data frame: this is a read-address frame again.
        rd_addr_frame(10'h2C3);

        // Abort a write after 5 bits; rx_data must hold, no pulse.
        rxv0     = n_rxv;
        bus.SS_n = 1'b0;
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk);
            bus.MOSI = (i % 2 == 0) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        @(negedge clk);
        check_eq("abort_no_pulse", n_rxv - rxv0, 32'd0);
        check_eq("abort_rx_hold", {22'd0, bus.rx_data}, {22'd0, last_rx});
        wr_frame(10'h0F0);

        // rd_addr_done still 1 (write/abort keep it): read data, reset during bit 3.
        rd_frame(10'h3AB, 8'h3C, 0, 3, 0);

        // Reset cleared rd_addr_done: MOSI=1 frame is a read address.
        rd_addr_frame(10'h2AA);

        // Late tx_valid, then tx_valid stuck high with SS_n held low.
        rd_frame(10'h355, 8'h96, 4, -1, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

- Serial front end of the SPI-to-memory path.
- Deserialises 10-bit command words from MOSI and presents them to the single-port memory as `rx_data`/`rx_valid`.
- For read-data commands, captures the memory's `tx_data` byte and shifts it back out on MISO.
- The SPI bit clock is the system clock `clk`: one MOSI bit is sampled per rising edge while `SS_n` is low.

## Interface
Parameters:
- None. Frame widths are fixed: 10-bit command word, 8-bit read byte.

Ports:
- `clk`  in  1  system clock, also the SPI bit clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `SS_n`  in  1  slave select, active low. High at any edge aborts the frame.
- `MOSI`  in  1  serial command data, MSB first.
- `MISO`  out  1  serial read data, MSB first; 0 when not shifting.
- `rx_data`  out  10  assembled word; `[9:8]` = command, `[7:0]` = address or data.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` is valid.
- `tx_data`  in  8  read byte from memory.
- `tx_valid`  in  1  `tx_data` valid; may stay high indefinitely.

## Operation
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, `MISO`=0, `rd_addr_done`=0, bit counter 0, wait/shift flags clear.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- **IDLE:** `SS_n`=0 → CHK_CMD; otherwise stay.
- **CHK_CMD:** sample MOSI as bit 9 into the shift register.
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_done`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_done`=1 → READ_DATA.
- **WRITE, READ_ADD, READ_DATA:** shift in 9 further bits (bits 8..0), MSB first.
  - On the edge that samples bit 0: `rx_data` ← the 10 assembled bits and `rx_valid` ← 1 for exactly one cycle.
  - Further MOSI bits in the same frame are ignored.
- **`rd_addr_done` flag:**
  - Set at frame completion in READ_ADD.
  - Cleared at frame completion in READ_DATA.
  - Unchanged by WRITE frames and by aborts.
- **READ_DATA after `rx_valid`:** set the wait flag.
  - The first edge that samples `tx_valid`=1 with the wait flag set captures `tx_data`, clears the wait flag and drives `MISO` ← bit 7.
  - The next 7 edges drive bits 6..0.
  - The edge after bit 0 drives `MISO` ← 0.
  - `tx_valid` staying high after the capture is ignored.
- **`tx_valid` outside the wait window:** ignored.
- **`SS_n`=1 at any edge in a non-IDLE state:**
  - Next state IDLE; counter cleared; wait/shift flags cleared; `MISO` ← 0.
  - No `rx_valid` for an incomplete frame; `rx_data` holds its last value.
- **Command bit 8:** not checked. The 10-bit word is forwarded as received and the memory decodes `[9:8]`.
- **`rst`:** has priority over every other condition at any point, including mid-frame and mid-shift.

## Timing
- E0 = first edge with `SS_n`=0 (IDLE → CHK_CMD).
- E1 samples bit 9; E2..E10 sample bits 8..0.
- `rx_data`/`rx_valid` update at E10; `rx_valid` is high between E10 and E11 only.
- With the memory registering `tx_valid` at E11:
  - E12 captures `tx_data` and drives `MISO`=bit 7.
  - E19 drives bit 0.
  - E20 returns `MISO` to 0.
- The master holds `SS_n` low through E20 for a read-data frame and through E10 for other frames.
- Back-to-back frames: `SS_n` high for at least one edge returns to IDLE, then a new frame starts.
- Minimum frame-to-frame spacing is 1 cycle high.

## Test plan
- **Write-address frame:** after reset, `SS_n` low, MOSI 00_0011_1100 → `rx_data`=0x03C, `rx_valid` high for one cycle at E10, `MISO`=0 throughout.
- **Write-data frame:** MOSI 01_1010_0101 → `rx_data`=0x1A5, one `rx_valid` pulse; `rd_addr_done` stays 0.
- **Read sequence:**
  - Read-address frame 10_0011_1100 → `rx_data`=0x23C and `rd_addr_done`=1.
  - Next frame 11_0000_0000 → `rx_data`=0x300.
  - Model drives `tx_data`=0xA5, `tx_valid`=1 from E11 onward → `MISO` 1,0,1,0,0,1,0,1 at E12..E19, then 0.
  - `rd_addr_done`=0 afterwards.
- **Abort:** `SS_n` raised after 5 bits of a write frame → no `rx_valid`, state IDLE, `rx_data` unchanged. The following full frame 00_1111_0000 → `rx_data`=0x0F0.
- **Reset during read:** `rst`=1 for one cycle during MISO bit 3 → `MISO`=0 at the next edge, `rd_addr_done`=0, `rx_valid`=0. A new MOSI=1 frame goes to READ_ADD.
- **Late/ignored `tx_valid`:**
  - `tx_valid` delayed 4 cycles after `rx_valid` → MISO shifting starts on the first edge seeing it.
  - `tx_valid` stuck high → no second byte is shifted.
